spart_bus_arbiter: RTL

Shares one SPART processor-side bus (iocs/iorw/ioaddr/databus) between two requesters, e.g. a baud/config client and a TX/RX data client. Arbitrates round-robin, holds each access until the SPART is ready (tbr for TX writes, rda for RX reads), and performs exactly one bus cycle per granted request. A wait timeout guarantees that a stalled SPART cannot lock out the other requester.

---
 rtl/spart_bus_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spart_bus_arbiter.sv
// Two-requester round-robin arbiter for the SPART processor-side bus.
// One bus cycle per grant; waits on tbr/rda for data accesses, with an optional timeout.
module spart_bus_arbiter #(
  parameter logic [15:0] WAIT_MAX = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr
);

  typedef enum logic [1:0] {StIdle, StWaitRdy, StXfer, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        winner;
  logic        ready;
  logic        xfer;
  logic [15:0] cnt_sat;

  // With the timeout disabled the counter just parks at its maximum.
  assign cnt_sat = (WAIT_MAX == 16'd0) ? 16'hFFFF : WAIT_MAX;
  assign winner  = (req0 && req1) ? ~last_q : req1;
  assign ready   = (addr_q != 2'b00) ? 1'b1 : (rw_q ? rda : tbr);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d = winner;
          addr_d  = winner ? addr1 : addr0;
          rw_d    = winner ? rw1 : rw0;
          wdata_d = winner ? wdata1 : wdata0;
          cnt_d   = 16'd0;
          state_d = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (ready) begin
          state_d = StXfer;
        end else if ((WAIT_MAX != 16'd0) && (cnt_q == WAIT_MAX)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (cnt_q != cnt_sat) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StXfer: begin
        if (rw_q) rdata_d = databus;
        state_d = StDone;
      end
      StDone: begin
        last_d  = owner_q;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= 2'b00;
      rw_q    <= 1'b1;
      wdata_q <= 8'h00;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign xfer    = (state_q == StXfer);
  assign iocs    = xfer;
  assign iorw    = xfer ? rw_q : 1'b1;
  assign ioaddr  = xfer ? addr_q : 2'b00;
  assign databus = (xfer && !rw_q) ? wdata_q : 8'hzz;
  assign done0   = (state_q == StDone) && !owner_q;
  assign done1   = (state_q == StDone) && owner_q;
  assign err     = (state_q == StDone) && err_q;
  assign busy    = (state_q != StIdle);
  assign rdata   = rdata_q;

endmodule
